uart_rfifo: RTL
===============

// Module: uart_rfifo
// PURPOSE
// Receive-side FIFO of the UART: buffers characters from the RX deserializer until the
// host reads the RBR. Each entry stores the character plus 3 line-error bits:
// {break, framing, parity}. Provides the LSR overrun bit, the LSR bit-7 "error in
// FIFO" flag and a fill count for the trigger-level logic. It pairs with the TX FIFO.
// PARAMETERS
// fifo_width      8   character width in bits
// fifo_depth      16  number of entries
// fifo_pointer_w  4   pointer width; fifo_depth == 2**fifo_pointer_w
// fifo_counter_w  5   count width; holds 0..fifo_depth
// PORTS
// clk            in   1                 system clock, all logic on posedge
// rst            in   1                 synchronous reset, active-high
// push           in   1                 write strobe from the RX deserializer, 1 cycle per char
// pop            in   1                 read strobe (host RBR read), 1 cycle per char
// data_in        in   fifo_width        received character
// err_in         in   3                 {break, framing, parity} for data_in
// fifo_clear     in   1                 FCR RX-clear strobe
// clear_overrun  in   1                 LSR-read strobe; clears overrun
// data_out       out  fifo_width        character at bottom of FIFO
// err_out        out  3                 error bits of the bottom entry
// count          out  fifo_counter_w    entries held
// empty          out  1                 count == 0
// full           out  1                 count == fifo_depth
// overrun        out  1                 sticky: a push was dropped
// error_flag     out  1                 at least one held entry has a nonzero err field
// BEHAVIOUR
// - Priority each cycle: rst > fifo_clear > push/pop.
// - Reset: top=bottom=0, count=0, err_cnt=0, overrun=0.
//   Outputs after reset: empty=1, full=0, error_flag=0, data_out=0, err_out=0.
// - fifo_clear: same effect as reset on top, bottom, count and err_cnt. Any push or pop
//   in that cycle is discarded. overrun is NOT cleared by fifo_clear.
// - Storage: internal array of fifo_width+3 bits. Writes are synchronous at mem[top].
//   Reads are combinational from mem[bottom]: zero latency.
//   data_out and err_out are forced to 0 while empty=1.
// - Pointers wrap modulo fifo_depth (natural pointer-width overflow). count does not wrap.
// - push only, count<depth: write mem[top]; top+1; count+1.
// - push only, count==depth: no write; pointers and count unchanged; overrun<=1.
// - pop only, count>0: bottom+1; count-1.
// - pop only, count==0: ignored; no state change.
// - push & pop, 0<count<=depth: write mem[top]; top+1; bottom+1; count unchanged.
//   This case is never an overrun, even when full.
// - push & pop, count==0: the push is accepted and the pop is ignored; count becomes 1.
// - err_cnt (fifo_counter_w bits, internal) tracks held entries with |err != 0:
//   +1 on an accepted push with |err_in; -1 on an accepted pop with |err_out.
//   If both happen in the same cycle, err_cnt is unchanged.
//   error_flag = (err_cnt != 0), combinational from the register.
// - overrun: set on a dropped push, cleared by clear_overrun. If set and clear occur in
//   the same cycle, set wins (overrun stays 1).
// - Status (count, empty, full, error_flag) updates on the edge after the strobe.
//   data_out shows a new entry 1 cycle after a push into an empty FIFO.
// TESTING
// 1. rst=1 for 1 clk -> count=0, empty=1, full=0, overrun=0, error_flag=0, data_out=0.
// 2. Push 8'h41..8'h50 (16 chars, err=0) -> full=1, count=16.
//    Then push 8'h99 -> overrun=1, count=16. Pop 16 -> data_out reads 41..50, then empty=1.
// 3. At count=16, push & pop together -> count stays 16, overrun stays 0;
//    the last pop returns the new char.
// 4. Push 8'h55 with err=3'b010, then 2 clean chars -> error_flag=1.
//    Pop 1 -> err_out was 3'b010 before the pop; error_flag=0 after the pop.
// 5. Empty FIFO, push 8'hA5 & pop together -> count=1, data_out=8'hA5 on the next cycle.
//    Pop with count=0 -> no change.
// 6. Fill 5 entries with 1 errored entry and overrun=1, then fifo_clear -> count=0,
//    error_flag=0, overrun=1. Then clear_overrun -> overrun=0.
//    Drop a push (FIFO full) with clear_overrun in the same cycle -> overrun=1.
//    Pointer wrap: 40 push/pop pairs -> data in order.

Source files
------------

// File: rtl/uart_rfifo.sv
// Receive-side UART FIFO: buffers characters with their {break, framing, parity} bits,
// and provides the overrun, error-in-FIFO and fill-count status for the LSR and trigger logic.
module uart_rfifo #(
    parameter int fifo_width     = 8,
    parameter int fifo_depth     = 16,
    parameter int fifo_pointer_w = 4,
    parameter int fifo_counter_w = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [fifo_width-1:0]     data_in,
    input  logic [2:0]                err_in,
    input  logic                      fifo_clear,
    input  logic                      clear_overrun,
    output logic [fifo_width-1:0]     data_out,
    output logic [2:0]                err_out,
    output logic [fifo_counter_w-1:0] count,
    output logic                      empty,
    output logic                      full,
    output logic                      overrun,
    output logic                      error_flag
);

    localparam logic [fifo_counter_w-1:0] depth_c = fifo_counter_w'(fifo_depth);
    localparam logic [fifo_counter_w-1:0] one_c   = fifo_counter_w'(1);
    localparam logic [fifo_pointer_w-1:0] step_c  = fifo_pointer_w'(1);

    // Each entry is {character, break, framing, parity}.
    logic [fifo_width+2:0]     mem [fifo_depth];
    logic [fifo_pointer_w-1:0] top;
    logic [fifo_pointer_w-1:0] bottom;
    logic [fifo_counter_w-1:0] err_cnt;
    logic [fifo_width+2:0]     bottom_word;

    logic push_ok;
    logic pop_ok;
    logic drop;
    logic err_inc;
    logic err_dec;

    assign empty       = (count == '0);
    assign full        = (count == depth_c);
    assign bottom_word = mem[bottom];
    assign data_out    = empty ? '0 : bottom_word[fifo_width+2:3];
    assign err_out     = empty ? '0 : bottom_word[2:0];
    assign error_flag  = (err_cnt != '0);

    // A simultaneous pop frees the slot, so a push into a full FIFO is only dropped alone.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok && !fifo_clear;
    assign err_inc = push_ok && (err_in != 3'b000);
    assign err_dec = pop_ok && (err_out != 3'b000);

    always_ff @(posedge clk) begin
        if (!rst && !fifo_clear && push_ok) begin
            mem[top] <= {data_in, err_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fifo_clear) begin
            top     <= '0;
            bottom  <= '0;
            count   <= '0;
            err_cnt <= '0;
        end else begin
            if (push_ok) begin
                top <= top + step_c;
            end
            if (pop_ok) begin
                bottom <= bottom + step_c;
            end
            if (push_ok && !pop_ok) begin
                count <= count + one_c;
            end else if (pop_ok && !push_ok) begin
                count <= count - one_c;
            end
            if (err_inc && !err_dec) begin
                err_cnt <= err_cnt + one_c;
            end else if (err_dec && !err_inc) begin
                err_cnt <= err_cnt - one_c;
            end
        end
    end

    // Overrun survives fifo_clear; a new drop wins over a same-cycle LSR read.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule
